// File: rtl/if_serdes.sv
// if_serdes: serial command/read-data shifter for a pad-level interface.
// A one-entry command buffer feeds a 7-bit transmit shifter at each frame
// start. A 10-bit receive shifter assembles read words into a one-entry
// output register. Sticky flags report dropped read words and frames that
// ended partway through a read word.
module if_serdes (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [6:0] cmd_data,
    output logic       cmd_ready,
    input  logic       load_cmd,
    input  logic       trst,
    input  logic       dq_en,
    input  logic       sr_en,
    input  logic       dq_in,
    output logic       dq_out,
    output logic       dq_oe,
    output logic [9:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       overrun,
    output logic       short_frame
);

    localparam logic [2:0] TX_BITS = 3'd7;
    localparam logic [3:0] RX_BITS = 4'd10;

    logic [6:0] cmd_buf_q, cmd_buf_d;
    logic       buf_full_q, buf_full_d;
    logic [6:0] tx_sr_q, tx_sr_d;
    logic [2:0] tx_cnt_q, tx_cnt_d;
    logic [9:0] rx_sr_q, rx_sr_d;
    logic [3:0] rx_cnt_q, rx_cnt_d;
    logic [9:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       overrun_q, overrun_d;
    logic       short_q, short_d;
    logic       dq_oe_q, dq_oe_d;

    logic       cmd_acc;
    logic       tx_shift;
    logic       rx_cap;
    logic       rx_done;
    logic [9:0] rx_word;

    // Frame start wins over shifting and capture in the same cycle.
    assign cmd_acc  = cmd_valid & ~buf_full_q;
    assign tx_shift = ~load_cmd & dq_en & ~sr_en & (tx_cnt_q < TX_BITS);
    assign rx_cap   = ~load_cmd & sr_en & ~dq_en & trst & (rx_cnt_q < RX_BITS);
    assign rx_word  = {rx_sr_q[8:0], dq_in};
    assign rx_done  = rx_cap & (rx_cnt_q == RX_BITS - 4'd1);

    // Next-state logic for buffer, shifters, read register and flags.
    always_comb begin
        cmd_buf_d  = cmd_buf_q;
        buf_full_d = buf_full_q;
        tx_sr_d    = tx_sr_q;
        tx_cnt_d   = tx_cnt_q;
        rx_sr_d    = rx_sr_q;
        rx_cnt_d   = rx_cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        overrun_d  = overrun_q;
        short_d    = short_q;
        dq_oe_d    = dq_en;

        if (load_cmd) begin
            // Empty buffer sends a NOP so the frame still has a defined command.
            tx_sr_d    = buf_full_q ? cmd_buf_q : 7'h00;
            buf_full_d = 1'b0;
            tx_cnt_d   = 3'd0;
            rx_cnt_d   = 4'd0;
            if (rx_cnt_q != 4'd0 && rx_cnt_q < RX_BITS)
                short_d = 1'b1;
        end else begin
            if (tx_shift) begin
                tx_sr_d  = {tx_sr_q[5:0], 1'b0};
                tx_cnt_d = tx_cnt_q + 3'd1;
            end
            if (!trst) begin
                rx_cnt_d = 4'd0;
            end else if (rx_cap) begin
                rx_sr_d  = rx_word;
                rx_cnt_d = rx_cnt_q + 4'd1;
            end
        end

        // A command offered alongside a NOP load stays for the next frame.
        if (cmd_acc) begin
            cmd_buf_d  = cmd_data;
            buf_full_d = 1'b1;
        end

        if (rd_valid_q && rd_ready)
            rd_valid_d = 1'b0;

        // Completed word goes out if the slot is free or being drained now.
        if (rx_done) begin
            if (!rd_valid_q || rd_ready) begin
                rd_data_d  = rx_word;
                rd_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_buf_q  <= 7'h00;
            buf_full_q <= 1'b0;
            tx_sr_q    <= 7'h00;
            tx_cnt_q   <= 3'd0;
            rx_sr_q    <= 10'h000;
            rx_cnt_q   <= 4'd0;
            rd_data_q  <= 10'h000;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            short_q    <= 1'b0;
            dq_oe_q    <= 1'b0;
        end else begin
            cmd_buf_q  <= cmd_buf_d;
            buf_full_q <= buf_full_d;
            tx_sr_q    <= tx_sr_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_sr_q    <= rx_sr_d;
            rx_cnt_q   <= rx_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overrun_q  <= overrun_d;
            short_q    <= short_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    assign cmd_ready   = ~buf_full_q;
    assign dq_out      = tx_sr_q[6];
    assign dq_oe       = dq_oe_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign overrun     = overrun_q;
    assign short_frame = short_q;

endmodule

// File: tb/tb_if_serdes.sv
// tb_if_serdes: directed scenarios plus random traffic, every cycle checked
// against a queue-based reference model of the serdes behaviour.
module tb_if_serdes;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [6:0] cmd_data;
    logic       cmd_ready;
    logic       load_cmd, trst, dq_en, sr_en, dq_in;
    logic       dq_out, dq_oe;
    logic [9:0] rd_data;
    logic       rd_valid, rd_ready;
    logic       overrun, short_frame;

    int n_chk  = 0;
    int n_fail = 0;

    if_serdes dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .load_cmd(load_cmd), .trst(trst), .dq_en(dq_en), .sr_en(sr_en),
        .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .overrun(overrun), .short_frame(short_frame)
    );

    always #5 clk = ~clk;

    // Reference model state: pending commands, bits left to send, bits received.
    logic [6:0] m_cmdq[$];
    bit         m_txq[$];
    bit         m_rxq[$];
    logic [9:0] m_rd_data;
    bit         m_rd_valid, m_ovr, m_short, m_oe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cmdq.delete(); m_txq.delete(); m_rxq.delete();
        m_rd_data = '0; m_rd_valid = 0; m_ovr = 0; m_short = 0; m_oe = 0;
    endtask

    task automatic model_step();
        bit         acc, old_v, deliv;
        logic [6:0] w;
        logic [9:0] word;
        acc   = cmd_valid && (m_cmdq.size() == 0);
        old_v = m_rd_valid;
        deliv = 0;
        m_oe  = dq_en;
        if (load_cmd) begin
            w = 7'h00;
            if (m_cmdq.size() > 0) w = m_cmdq.pop_front();
            m_txq.delete();
            for (int i = 6; i >= 0; i--) m_txq.push_back(w[i]);
            if (m_rxq.size() > 0 && m_rxq.size() < 10) m_short = 1;
            m_rxq.delete();
        end else begin
            if (dq_en && !sr_en && m_txq.size() > 0) void'(m_txq.pop_front());
            if (!trst) m_rxq.delete();
            else if (sr_en && !dq_en && m_rxq.size() < 10) begin
                m_rxq.push_back(dq_in);
                if (m_rxq.size() == 10) begin
                    word = '0;
                    foreach (m_rxq[i]) word = {word[8:0], m_rxq[i]};
                    if (!old_v || rd_ready) begin
                        m_rd_data = word; m_rd_valid = 1; deliv = 1;
                    end else m_ovr = 1;
                end
            end
        end
        if (acc) m_cmdq.push_back(cmd_data);
        if (old_v && rd_ready && !deliv) m_rd_valid = 0;
    endtask

    task automatic compare_all();
        chk("dq_out",      dq_out,      (m_txq.size() > 0) ? m_txq[0] : 1'b0);
        chk("cmd_ready",   cmd_ready,   m_cmdq.size() == 0);
        chk("dq_oe",       dq_oe,       m_oe);
        chk("rd_valid",    rd_valid,    m_rd_valid);
        chk("rd_data",     rd_data,     m_rd_data);
        chk("overrun",     overrun,     m_ovr);
        chk("short_frame", short_frame, m_short);
    endtask

    // One clock: model follows the edge, outputs compared 1ns later.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_data = '0; load_cmd = 0; trst = 1;
        dq_en = 0; sr_en = 0; dq_in = 0; rd_ready = 0;
    endtask

    // Asynchronous reset pulse starting between clock edges.
    task automatic do_reset();
        rst_n = 0;
        #1;
        model_reset();
        compare_all();
        chk("rst_dq_out", dq_out, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_flags", {overrun, short_frame, dq_oe}, 3'b000);
        idle_inputs();
        tick();
        rst_n = 1;
    endtask

    task automatic read_frame(input logic [9:0] word, input logic rdy);
        rd_ready = rdy; trst = 1; load_cmd = 1;
        tick();
        load_cmd = 0; sr_en = 1;
        for (int i = 9; i >= 0; i--) begin
            dq_in = word[i];
            tick();
        end
        sr_en = 0;
    endtask

    task automatic shift_out(output logic [6:0] got);
        dq_en = 1;
        for (int i = 6; i >= 0; i--) begin
            got[i] = dq_out;
            tick();
            chk("oe_follow", dq_oe, 1);
        end
        dq_en = 0;
    endtask

    logic [6:0] got7;
    logic [9:0] w10;

    initial begin
        idle_inputs();
        rst_n = 0;
        #2;
        model_reset();
        compare_all();
        tick();
        tick();
        rst_n = 1;
        tick();

        // Command 5A shifted out MSB first.
        cmd_valid = 1; cmd_data = 7'h5A;
        tick();
        cmd_valid = 0;
        chk("buf_full", cmd_ready, 0);
        load_cmd = 1;
        tick();
        load_cmd = 0;
        chk("buf_drained", cmd_ready, 1);
        shift_out(got7);
        chk("tx_5A", got7, 7'h5A);
        tick();
        chk("oe_drop", dq_oe, 0);
        chk("tx_idle_zero", dq_out, 0);

        // Read of 2C5 with consumer ready: one-cycle rd_valid.
        w10 = 10'h2C5;
        rd_ready = 1; trst = 1; load_cmd = 1;
        tick();
        load_cmd = 0; sr_en = 1;
        for (int i = 9; i >= 0; i--) begin
            dq_in = w10[i];
            tick();
            if (i > 0) chk("rd_not_yet", rd_valid, 0);
        end
        sr_en = 0;
        chk("rd_valid_2C5", rd_valid, 1);
        chk("rd_data_2C5", rd_data, 10'h2C5);
        tick();
        chk("rd_one_cycle", rd_valid, 0);

        // Overrun: second word dropped while first is unconsumed.
        do_reset();
        read_frame(10'h155, 0);
        read_frame(10'h0AA, 0);
        chk("ovr_data", rd_data, 10'h155);
        chk("ovr_valid", rd_valid, 1);
        chk("ovr_flag", overrun, 1);
        rd_ready = 1;
        tick();
        rd_ready = 0;
        chk("ovr_sticky", overrun, 1);

        // Late command alongside a NOP load.
        do_reset();
        load_cmd = 1; cmd_valid = 1; cmd_data = 7'h33;
        tick();
        load_cmd = 0; cmd_valid = 0;
        chk("late_buffered", cmd_ready, 0);
        shift_out(got7);
        chk("nop_frame", got7, 7'h00);
        chk("still_buffered", cmd_ready, 0);
        load_cmd = 1;
        tick();
        load_cmd = 0;
        shift_out(got7);
        chk("late_frame", got7, 7'h33);

        // Short frame: load after 6 strobes.
        do_reset();
        load_cmd = 1;
        tick();
        load_cmd = 0; sr_en = 1;
        for (int i = 0; i < 6; i++) begin dq_in = i[0]; tick(); end
        sr_en = 0; load_cmd = 1;
        tick();
        load_cmd = 0;
        chk("short_set", short_frame, 1);
        chk("short_no_rd", rd_valid, 0);

        // Mid-frame reset then a clean frame; trst low does not flag short.
        do_reset();
        load_cmd = 1;
        tick();
        load_cmd = 0; sr_en = 1;
        for (int i = 0; i < 4; i++) begin dq_in = 1; tick(); end
        sr_en = 0;
        do_reset();
        chk("mid_rst_short", short_frame, 0);
        read_frame(10'h3A7, 1);
        chk("post_rst_data", rd_data, 10'h3A7);
        chk("post_rst_valid", rd_valid, 1);
        sr_en = 1; dq_in = 1;
        load_cmd = 1; tick(); load_cmd = 0;
        tick(); tick();
        trst = 0; sr_en = 0;
        tick();
        trst = 1; load_cmd = 1;
        tick();
        load_cmd = 0;
        chk("trst_no_short", short_frame, 0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 699) == 0) do_reset();
            cmd_valid = $urandom_range(0, 1);
            cmd_data  = 7'($urandom);
            load_cmd  = ($urandom_range(0, 17) == 0);
            trst      = ($urandom_range(0, 24) != 0);
            sr_en     = ($urandom_range(0, 3) != 0);
            dq_en     = ($urandom_range(0, 3) == 0);
            dq_in     = $urandom_range(0, 1);
            rd_ready  = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
